posit_mac_accum: RTL



---
 rtl/posit_mac_accum.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/posit_mac_accum.sv
// Exact posit product-accumulate stage: multiplies decoded operand pairs and sums LEN products in a quire.
// Optional build macro POSIT_MAC_CLR_EN adds a clr_i input that abandons the current vector.
module posit_mac_accum #(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int LEN   = 16,
  localparam int MTS  = WIDTH - 3 - EXP,
  localparam int REGI = $clog2(WIDTH) + 1,
  localparam int SMAX = 2 * ((WIDTH - 2) * (2 ** EXP) + (2 ** EXP) - 1),
  localparam int FRAC = SMAX + 2 * MTS,
  localparam int QW   = SMAX + FRAC + 2 + $clog2(LEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
`ifdef POSIT_MAC_CLR_EN
  input  logic            clr_i,
`endif
  input  logic            vld_i,
  input  logic            sign_a,
  input  logic            sign_b,
  input  logic [REGI-1:0] regi_a,
  input  logic [REGI-1:0] regi_b,
  input  logic [EXP-1:0]  exp_a,
  input  logic [EXP-1:0]  exp_b,
  input  logic [MTS-1:0]  mts_a,
  input  logic [MTS-1:0]  mts_b,
  input  logic [1:0]      cls_a,
  input  logic [1:0]      cls_b,
  output logic [QW-1:0]   acc_o,
  output logic            nar_o,
  output logic            vld_o,
  output logic            busy_o
);

  localparam int SW = $clog2(SMAX) + 2;
  localparam int MW = 2 * MTS + 2;
  localparam int CW = $clog2(LEN + 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACC
  } state_e;

  logic clr_w;
`ifdef POSIT_MAC_CLR_EN
  assign clr_w = clr_i;
`else
  assign clr_w = 1'b0;
`endif

  // Stage 1: exact product of the two significands and combined scale
  logic [SW-1:0] reg_a_x, reg_b_x, scale_c;
  logic [MW-1:0] m_c;
  logic          zero_c, nar_c;

  always_comb begin
    reg_a_x = {{(SW-REGI){regi_a[REGI-1]}}, regi_a};
    reg_b_x = {{(SW-REGI){regi_b[REGI-1]}}, regi_b};
    scale_c = ((reg_a_x + reg_b_x) << EXP) + SW'(exp_a) + SW'(exp_b);
    m_c     = MW'({1'b1, mts_a}) * MW'({1'b1, mts_b});
    zero_c  = (cls_a == 2'b00) | (cls_b == 2'b00);
    nar_c   = (cls_a == 2'b10) | (cls_b == 2'b10);
  end

  logic          s1_vld_q, s1_vld_d;
  logic          s1_sign_q;
  logic [SW-1:0] s1_scale_q;
  logic [MW-1:0] s1_m_q;
  logic          s1_zero_q, s1_nar_q;

  // Stage 2: align product into the quire and accumulate
  state_e        state_q, state_d;
  logic [QW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nar_q, nar_d;
  logic [QW-1:0] acc_o_q, acc_o_d;
  logic          nar_o_q, nar_o_d;
  logic          vld_o_q, vld_o_d;

  logic [SW-1:0] shamt;
  logic [QW-1:0] mag, term, base, sum;
  logic          last;

  always_comb begin
    shamt = s1_scale_q + SW'(SMAX);
    mag   = QW'(s1_m_q) << shamt;
    term  = (s1_zero_q | s1_nar_q) ? '0 : (s1_sign_q ? -mag : mag);
    // In IDLE the accumulator is known to be empty, so the first term starts from zero
    base  = (state_q == ST_IDLE) ? '0 : acc_q;
    sum   = base + term;
    last  = s1_vld_q && (cnt_q == CW'(LEN - 1));
  end

  always_comb begin
    s1_vld_d = vld_i & ~clr_w;
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nar_d    = nar_q;
    acc_o_d  = acc_o_q;
    nar_o_d  = nar_o_q;
    vld_o_d  = 1'b0;
    if (clr_w) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      nar_d   = 1'b0;
    end else if (s1_vld_q) begin
      if (last) begin
        nar_o_d = nar_q | s1_nar_q;
        acc_o_d = (nar_q | s1_nar_q) ? '0 : sum;
        vld_o_d = 1'b1;
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        nar_d   = 1'b0;
      end else begin
        state_d = ST_ACC;
        acc_d   = sum;
        cnt_d   = cnt_q + CW'(1);
        nar_d   = nar_q | s1_nar_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_scale_q <= '0;
      s1_m_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      nar_q      <= 1'b0;
      acc_o_q    <= '0;
      nar_o_q    <= 1'b0;
      vld_o_q    <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_sign_q  <= sign_a ^ sign_b;
      s1_scale_q <= scale_c;
      s1_m_q     <= m_c;
      s1_zero_q  <= zero_c;
      s1_nar_q   <= nar_c;
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      nar_q      <= nar_d;
      acc_o_q    <= acc_o_d;
      nar_o_q    <= nar_o_d;
      vld_o_q    <= vld_o_d;
    end
  end

  assign acc_o  = acc_o_q;
  assign nar_o  = nar_o_q;
  assign vld_o  = vld_o_q;
  assign busy_o = (cnt_q != '0) | s1_vld_q;

endmodule
